// File: rtl/mapmov_symbol_framer.sv
// Strips the mapper/mover packet header and re-frames the sample stream into fixed-length IFFT symbols.
// Optional zero-padding of short final symbols: MAPMOV_SYMBOL_FRAMER_PAD_EN.
module mapmov_symbol_framer #(
   parameter int SYMBOL_LEN = 1024,
   parameter int HDR_WORDS  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] t_data,
   input  logic        t_last,
   input  logic        t_valid,
   output logic        t_ready,
   output logic [31:0] i_data,
   output logic        i_last,
   output logic        i_valid,
   input  logic        i_ready,
   output logic [31:0] o_vector_type,
   output logic [15:0] o_sym_cnt,
   output logic [7:0]  o_err_cnt,
   output logic        o_busy
);
   localparam int SW = $clog2(SYMBOL_LEN);
   localparam int HW = $clog2(HDR_WORDS + 1);
   localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_LEN - 1);
   localparam logic [HW-1:0] HDR_LAST = HW'(HDR_WORDS - 1);
   localparam logic [HW-1:0] HDR_VT   = HW'(4);

`ifdef MAPMOV_SYMBOL_FRAMER_PAD_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

   state_t        state_q, state_d;
   logic [HW-1:0] hdr_idx_q, hdr_idx_d;
   logic [SW-1:0] sym_idx_q, sym_idx_d;
   logic [31:0]   vt_q, vt_d;
   logic [15:0]   sym_cnt_q, sym_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          sym_inc, err_inc, sym_last;

   assign sym_last = (sym_idx_q == SYM_LAST);

   always_comb begin
      state_d   = state_q;
      hdr_idx_d = hdr_idx_q;
      sym_idx_d = sym_idx_q;
      vt_d      = vt_q;
      sym_inc   = 1'b0;
      err_inc   = 1'b0;
      t_ready   = 1'b1;
      i_valid   = 1'b0;
      i_data    = '0;
      i_last    = 1'b0;
      case (state_q)
         IDLE: begin
            // zero words are type-0 nulls; a non-zero single-word packet is malformed
            if (t_valid && t_data != 32'd0) begin
               if (t_last) err_inc = 1'b1;
               else begin
                  hdr_idx_d = HW'(1);
                  state_d   = HDR;
               end
            end
         end
         HDR: begin
            if (t_valid) begin
               hdr_idx_d = hdr_idx_q + HW'(1);
               if (hdr_idx_q == HDR_VT) vt_d = t_data;
               if (t_last) begin
                  err_inc = 1'b1;
                  state_d = IDLE;
               end else if (hdr_idx_q == HDR_LAST) begin
                  sym_idx_d = '0;
                  state_d   = DATA;
               end
            end
         end
         DATA: begin
            i_data  = t_data;
            i_valid = t_valid;
            t_ready = i_ready;
`ifdef MAPMOV_SYMBOL_FRAMER_PAD_EN
            i_last  = sym_last;
`else
            i_last  = sym_last | t_last;
`endif
            if (t_valid && i_ready) begin
               sym_idx_d = sym_last ? '0 : sym_idx_q + SW'(1);
               sym_inc   = sym_last;
               if (t_last) begin
                  if (sym_last) state_d = IDLE;
                  else begin
`ifdef MAPMOV_SYMBOL_FRAMER_PAD_EN
                     state_d = PAD;
`else
                     // short symbol is truncated: closed early and flagged
                     err_inc   = 1'b1;
                     sym_inc   = 1'b1;
                     sym_idx_d = '0;
                     state_d   = IDLE;
`endif
                  end
               end
            end
         end
`ifdef MAPMOV_SYMBOL_FRAMER_PAD_EN
         PAD: begin
            t_ready = 1'b0;
            i_valid = 1'b1;
            i_last  = sym_last;
            if (i_ready) begin
               sym_idx_d = sym_last ? '0 : sym_idx_q + SW'(1);
               if (sym_last) begin
                  sym_inc = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      sym_cnt_d = sym_inc ? sym_cnt_q + 16'd1 : sym_cnt_q;
      err_cnt_d = (err_inc && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hdr_idx_q <= '0;
         sym_idx_q <= '0;
         vt_q      <= '0;
         sym_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hdr_idx_q <= hdr_idx_d;
         sym_idx_q <= sym_idx_d;
         vt_q      <= vt_d;
         sym_cnt_q <= sym_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_vector_type = vt_q;
   assign o_sym_cnt     = sym_cnt_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mapmov_symbol_framer.sv
// Randomized bench for mapmov_symbol_framer: packets are driven word by word and the captured
// output stream is compared against a framing model built from sample counts.
module tb_mapmov_symbol_framer;
   localparam int L = 1024;
   localparam int H = 16;

   logic        clk, rst;
   logic [31:0] t_data;
   logic        t_last, t_valid, t_ready;
   logic [31:0] i_data;
   logic        i_last, i_valid, i_ready;
   logic [31:0] o_vector_type;
   logic [15:0] o_sym_cnt;
   logic [7:0]  o_err_cnt;
   logic        o_busy;

   mapmov_symbol_framer #(.SYMBOL_LEN(L), .HDR_WORDS(H)) dut (
      .clk(clk), .rst(rst), .t_data(t_data), .t_last(t_last), .t_valid(t_valid),
      .t_ready(t_ready), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
      .i_ready(i_ready), .o_vector_type(o_vector_type), .o_sym_cnt(o_sym_cnt),
      .o_err_cnt(o_err_cnt), .o_busy(o_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int to_cnt = 0, stalls = 0, pad_rdy = 0;
   bit rnd_ready = 0;
   int exp_sym = 0, exp_err = 0;
   logic [31:0] smp[$];
   logic [32:0] outq[$], expq[$];

   always @(negedge clk)
      if (!rst && i_valid && i_ready) outq.push_back({i_last, i_data});

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_word(input logic [31:0] d, input logic l, input bit gaps);
      bit acc = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         t_valid = 1'b0;
         step();
      end
      t_valid = 1'b1; t_data = d; t_last = l;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         acc = t_ready;
         if (!acc) stalls++;
         step();
         if (acc) break;
      end
      if (!acc) to_cnt++;
      t_valid = 1'b0; t_last = 1'b0; t_data = '0;
   endtask

   // after upstream's last word the framer may only be padding, never accepting
   task automatic wait_idle();
      int k;
      for (k = 0; k < 20000 && o_busy; k++) begin
         @(negedge clk);
         if (o_busy && t_ready) pad_rdy++;
         step();
      end
      if (o_busy) to_cnt++;
   endtask

   // framing model: symbols of L samples; a short tail is padded or truncated-and-flagged
   task automatic model(input int n);
      for (int i = 0; i < n; i++) begin
         logic lst;
         lst = ((i % L) == L - 1);
`ifndef MAPMOV_SYMBOL_FRAMER_PAD_EN
         if (i == n - 1) lst = 1'b1;
`endif
         expq.push_back({lst, smp[i]});
      end
      if (n % L != 0) begin
`ifdef MAPMOV_SYMBOL_FRAMER_PAD_EN
         for (int i = n; i < ((n + L - 1) / L) * L; i++)
            expq.push_back({((i % L) == L - 1), 32'd0});
`else
         if (exp_err < 255) exp_err++;
`endif
      end
      exp_sym = (exp_sym + (n + L - 1) / L) % 65536;
   endtask

   function automatic int first_diff();
      int m = (outq.size() < expq.size()) ? outq.size() : expq.size();
      for (int i = 0; i < m; i++) if (outq[i] !== expq[i]) return i;
      if (outq.size() != expq.size()) return m;
      return -1;
   endfunction

   task automatic send_hdr(input logic [31:0] vt, input bit gaps, input int nw, input bit last_on_end);
      for (int w = 0; w < nw; w++) begin
         logic [31:0] d;
         d = (w == 0) ? 32'h0000_0001 : (w == 4) ? vt : $urandom;
         send_word(d, last_on_end && (w == nw - 1), gaps);
      end
   endtask

   task automatic send_pkt(input int n, input logic [31:0] vt, input bit gaps);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back($urandom);
      send_hdr(vt, gaps, H, 0);
      for (int i = 0; i < n; i++) send_word(smp[i], i == n - 1, gaps);
      model(n);
      wait_idle();
   endtask

   task automatic clear_q();
      outq.delete(); expq.delete(); to_cnt = 0; stalls = 0; pad_rdy = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      total++; if ({t_ready, i_valid, i_last, o_busy} !== 4'b1000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 1000", {t_ready, i_valid, i_last, o_busy}); end
      total++; if (i_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", i_data); end
      total++; if ({o_vector_type, o_sym_cnt, o_err_cnt} !== 56'd0) begin
         bad++; $display("FAIL reset_regs: vt=%h sym=%0d err=%0d want 0", o_vector_type, o_sym_cnt, o_err_cnt); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_long_packet();
      clear_q();
      smp.delete();
      for (int i = 0; i < 2048; i++) smp.push_back($urandom);
      send_hdr(32'd5, 0, H, 0);
      total++; if (outq.size() != 0 || o_busy !== 1'b1) begin
         bad++; $display("FAIL hdr_silent: out=%0d busy=%b want 0/1", outq.size(), o_busy); end
      for (int i = 0; i < 2048; i++) send_word(smp[i], i == 2047, 0);
      model(2048);
      wait_idle();
      total++; if (first_diff() != -1) begin
         bad++; $display("FAIL long_seq: diff at %0d, out=%0d want %0d beats", first_diff(), outq.size(), expq.size()); end
      total++; if (o_sym_cnt !== 16'(exp_sym)) begin bad++; $display("FAIL long_sym: got %0d want %0d", o_sym_cnt, exp_sym); end
      total++; if (o_vector_type !== 32'd5) begin bad++; $display("FAIL long_vt: got %0d want 5", o_vector_type); end
      total++; if (to_cnt != 0) begin bad++; $display("FAIL long_timeout: got %0d want 0", to_cnt); end
   endtask

   task automatic test_null_words();
      clear_q();
      repeat (3) send_word(32'd0, 1'b1, 0);
      repeat (2) step();
      total++; if (outq.size() != 0 || stalls != 0) begin
         bad++; $display("FAIL null_quiet: out=%0d stalls=%0d want 0/0", outq.size(), stalls); end
      total++; if (o_err_cnt !== 8'(exp_err) || o_busy !== 1'b0) begin
         bad++; $display("FAIL null_err: err=%0d busy=%b want %0d/0", o_err_cnt, o_busy, exp_err); end
   endtask

   task automatic test_short_packet();
      clear_q();
      send_pkt(1500, 32'h77, 0);
      total++; if (first_diff() != -1) begin
         bad++; $display("FAIL short_seq: diff at %0d, out=%0d want %0d beats", first_diff(), outq.size(), expq.size()); end
      total++; if (o_sym_cnt !== 16'(exp_sym) || o_err_cnt !== 8'(exp_err)) begin
         bad++; $display("FAIL short_cnt: sym=%0d err=%0d want %0d/%0d", o_sym_cnt, o_err_cnt, exp_sym, exp_err); end
      total++; if (pad_rdy != 0 || to_cnt != 0) begin
         bad++; $display("FAIL short_pad_ready: ready_cycles=%0d timeouts=%0d want 0/0", pad_rdy, to_cnt); end
   endtask

   task automatic test_bad_header();
      clear_q();
      if (exp_err < 255) exp_err++;
      send_hdr(32'hbeef, 0, 8, 1);
      repeat (2) step();
      total++; if (o_err_cnt !== 8'(exp_err) || outq.size() != 0 || o_busy !== 1'b0) begin
         bad++; $display("FAIL badhdr: err=%0d out=%0d busy=%b want %0d/0/0", o_err_cnt, outq.size(), o_busy, exp_err); end
      total++; if (o_vector_type !== 32'hbeef) begin bad++; $display("FAIL badhdr_vt: got %h want beef", o_vector_type); end
      send_pkt(1024, 32'h9, 0);
      total++; if (first_diff() != -1 || o_sym_cnt !== 16'(exp_sym)) begin
         bad++; $display("FAIL badhdr_next: diff at %0d sym=%0d want -1/%0d", first_diff(), o_sym_cnt, exp_sym); end
   endtask

   task automatic test_random_flow();
      int n;
      clear_q();
      rnd_ready = 1;
      send_pkt(4096, 32'h3, 1);
      total++; if (first_diff() != -1) begin
         bad++; $display("FAIL rand_seq: diff at %0d, out=%0d want %0d beats", first_diff(), outq.size(), expq.size()); end
      clear_q();
      n = $urandom_range(1, 1100);
      send_pkt(n, 32'h4, 1);
      total++; if (first_diff() != -1) begin
         bad++; $display("FAIL rand_tail n=%0d: diff at %0d, out=%0d want %0d", n, first_diff(), outq.size(), expq.size()); end
      total++; if (o_sym_cnt !== 16'(exp_sym) || o_err_cnt !== 8'(exp_err) || to_cnt != 0 || pad_rdy != 0) begin
         bad++; $display("FAIL rand_cnt: sym=%0d err=%0d to=%0d pr=%0d want %0d/%0d/0/0",
                         o_sym_cnt, o_err_cnt, to_cnt, pad_rdy, exp_sym, exp_err); end
      rnd_ready = 0;
      i_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      clear_q();
      send_hdr(32'h6, 0, H, 0);
      for (int i = 0; i < 300; i++) send_word($urandom, 1'b0, 0);
      rst = 1'b1;
      step();
      total++; if (o_busy !== 1'b0 || i_valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_state: busy=%b ivalid=%b want 0/0", o_busy, i_valid); end
      total++; if ({o_vector_type, o_sym_cnt, o_err_cnt} !== 56'd0) begin
         bad++; $display("FAIL rstmid_regs: vt=%h sym=%0d err=%0d want 0", o_vector_type, o_sym_cnt, o_err_cnt); end
      rst = 1'b0;
      exp_sym = 0; exp_err = 0;
      step();
      clear_q();
      send_pkt(1024, 32'h8, 0);
      total++; if (first_diff() != -1 || o_sym_cnt !== 16'd1) begin
         bad++; $display("FAIL rstmid_fresh: diff at %0d sym=%0d want -1/1", first_diff(), o_sym_cnt); end
   endtask

   initial begin
      rst = 1'b1; t_valid = 1'b0; t_data = '0; t_last = 1'b0; i_ready = 1'b1;
      test_reset();
      test_long_packet();
      test_null_words();
      test_short_packet();
      test_bad_header();
      test_random_flow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
